// File: rtl/ram_responder.sv
// ram_responder: single-port word RAM behind a 2-entry in-order command FIFO.
// Each command is executed by an IDLE/BUSY/RESP controller and produces one
// ack pulse ACK_LATENCY cycles after execution starts.
// Optional build macro RAM_RESPONDER_STALL_EN adds a 16-bit LFSR that
// randomly withholds ram_accept_o (bit 0 of the LFSR high = stall).
module ram_responder #(
   parameter int ADDR_W      = 12,
   parameter int ACK_LATENCY = 2
) (
   input  logic        clk_ram,
   input  logic        rst_n,
   input  logic [3:0]  ram_wr_i,
   input  logic        ram_rd_i,
   input  logic [31:0] ram_addr_i,
   input  logic [31:0] ram_write_data_i,
   output logic        ram_accept_o,
   output logic        ram_ack_o,
   output logic [31:0] ram_read_data_o,
   output logic        ram_error_o
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam int CNT_W = 4;

   typedef struct packed {
      logic [3:0]  wr;
      logic        rd;
      logic [31:0] addr;
      logic [31:0] wdata;
   } cmd_t;

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   // Any address bit above the word-index field means the access misses the RAM.
   function automatic logic addr_out_of_range(input logic [31:0] a);
      return (a >> (ADDR_W + 2)) != 32'd0;
   endfunction

   cmd_t              cmd_in;
   cmd_t              fifo_p0 [0:1];
   cmd_t              head_p0;
   logic              wr_ptr_p0;
   logic              rd_ptr_p0;
   logic [1:0]        count_p0;
   logic              req;
   logic              full;
   logic              stall;
   logic              accept;
   logic              pop;
   logic              exec_err;
   logic              do_write;
   logic              do_read;
   logic [ADDR_W-1:0] word_idx;

   logic [31:0]       mem [0:DEPTH-1];
   state_t            state_p1;
   logic [CNT_W-1:0]  cnt_p1;
   logic              ack_p1;
   logic              err_p1;
   logic [31:0]       rdata_p1;

   assign cmd_in = {ram_wr_i, ram_rd_i, ram_addr_i, ram_write_data_i};
   assign req    = ram_rd_i | (|ram_wr_i);
   assign full   = (count_p0 == 2'd2);

`ifdef RAM_RESPONDER_STALL_EN
   logic [15:0] lfsr;

   // Free-running x^16+x^14+x^13+x^11+1 LFSR; bit 0 gates acceptance.
   always_ff @(posedge clk_ram or negedge rst_n) begin
      if (!rst_n) lfsr <= 16'hACE1;
      else        lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
   end

   assign stall = lfsr[0];
`else
   assign stall = 1'b0;
`endif

   // Fullness is judged on the registered count, so a same-cycle pop never frees a slot.
   assign accept       = rst_n & req & ~full & ~stall;
   assign ram_accept_o = accept;

   // ---- p0: command FIFO head decode ----
   assign head_p0  = fifo_p0[rd_ptr_p0];
   assign pop      = (state_p1 == IDLE) && (count_p0 != 2'd0);
   assign word_idx = head_p0.addr[ADDR_W+1:2];
   assign exec_err = addr_out_of_range(head_p0.addr) | (head_p0.rd & (|head_p0.wr));
   assign do_write = pop & (|head_p0.wr) & ~exec_err;
   assign do_read  = pop & head_p0.rd & ~exec_err;

   // FIFO storage: payload only, no reset needed.
   always_ff @(posedge clk_ram) begin
      if (accept) fifo_p0[wr_ptr_p0] <= cmd_in;
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge clk_ram or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_p0 <= 1'b0;
         rd_ptr_p0 <= 1'b0;
         count_p0  <= 2'd0;
      end else begin
         if (accept) wr_ptr_p0 <= ~wr_ptr_p0;
         if (pop)    rd_ptr_p0 <= ~rd_ptr_p0;
         case ({accept, pop})
            2'b10:   count_p0 <= count_p0 + 2'd1;
            2'b01:   count_p0 <= count_p0 - 2'd1;
            default: count_p0 <= count_p0;
         endcase
      end
   end

   // Byte-masked RAM write at the pop edge; contents survive reset.
   always_ff @(posedge clk_ram) begin
      if (do_write) begin
         for (int k = 0; k < 4; k++) begin
            if (head_p0.wr[k]) mem[word_idx][8*k +: 8] <= head_p0.wdata[8*k +: 8];
         end
      end
   end

   // ---- p1: execution result held until the ack cycle ----
   // Read data latched at the pop edge; writes and errors return zero.
   always_ff @(posedge clk_ram) begin
      if (pop) rdata_p1 <= do_read ? mem[word_idx] : 32'd0;
   end

   // Controller: IDLE pops, BUSY counts down the latency, RESP pulses ack.
   always_ff @(posedge clk_ram or negedge rst_n) begin
      if (!rst_n) begin
         state_p1 <= IDLE;
         cnt_p1   <= '0;
         ack_p1   <= 1'b0;
         err_p1   <= 1'b0;
      end else begin
         case (state_p1)
            IDLE: begin
               ack_p1 <= 1'b0;
               if (pop) begin
                  err_p1 <= exec_err;
                  if (ACK_LATENCY == 1) begin
                     state_p1 <= RESP;
                     ack_p1   <= 1'b1;
                     cnt_p1   <= '0;
                  end else begin
                     state_p1 <= BUSY;
                     cnt_p1   <= CNT_W'(ACK_LATENCY - 1);
                  end
               end
            end
            BUSY: begin
               cnt_p1 <= cnt_p1 - CNT_W'(1);
               if (cnt_p1 == CNT_W'(1)) begin
                  state_p1 <= RESP;
                  ack_p1   <= 1'b1;
               end
            end
            RESP: begin
               state_p1 <= IDLE;
               ack_p1   <= 1'b0;
            end
            default: begin
               state_p1 <= IDLE;
               ack_p1   <= 1'b0;
               cnt_p1   <= '0;
            end
         endcase
      end
   end

   // Data and error are only meaningful alongside ack; force zero otherwise.
   assign ram_ack_o       = ack_p1;
   assign ram_read_data_o = ack_p1 ? rdata_p1 : 32'd0;
   assign ram_error_o     = ack_p1 & err_p1;

endmodule
